// File: rtl/lcd_hex_driver.sv
// lcd_hex_driver: HD44780 init, then continuous refresh of a hex label (line 1) and a 32-bit word (line 2)
module lcd_hex_driver #(
    parameter int POWERUP_CYCLES = 750000,
    parameter int EN_CYCLES = 12,
    parameter int CMD_CYCLES = 2500,
    parameter int CLEAR_CYCLES = 100000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  LCDdataHEX,
    input  logic [31:0] LCDdata,
    output logic [7:0]  LCD_DATA,
    output logic        LCD_RS,
    output logic        LCD_RW,
    output logic        LCD_EN,
    output logic        LCD_ON,
    output logic        LCD_BLON,
    output logic        ready,
    output logic        frame_done
);
    localparam int M0 = POWERUP_CYCLES > CLEAR_CYCLES ? POWERUP_CYCLES : CLEAR_CYCLES;
    localparam int M1 = CMD_CYCLES > EN_CYCLES ? CMD_CYCLES : EN_CYCLES;
    localparam int CW = $clog2((M0 > M1 ? M0 : M1) + 1);
    typedef enum logic [2:0] {POWERUP, INIT, SNAP, L1_ADDR, L1_CHAR, L2_ADDR, L2_CHAR} state_t;
    typedef enum logic [1:0] {SETUP, PULSE, WAIT} phase_t;
    state_t state, state_n;
    phase_t phase, phase_n;
    logic [CW-1:0] cnt, cnt_n, wlim;
    logic [2:0] idx, idx_n;
    logic [7:0] shex, shex_n, tx;
    logic [31:0] sdat, sdat_n;
    logic ready_n, fd_n, xfer, last;
    function automatic logic [7:0] asc(input logic [3:0] n);
        return n < 4'd10 ? {4'h3, n} : 8'h37 + {4'h0, n};
    endfunction
    always_comb begin
        xfer = state != POWERUP && state != SNAP;
        tx = state == INIT ? (idx[1:0] == 2'd0 ? 8'h38 : idx[1:0] == 2'd1 ? 8'h0C : idx[1:0] == 2'd2 ? 8'h06 : 8'h01)
           : state == L1_ADDR ? 8'h80
           : state == L2_ADDR ? 8'hC0
           : state == L1_CHAR ? asc(idx[0] ? shex[3:0] : shex[7:4])
           : state == L2_CHAR ? asc(sdat[{~idx, 2'b00} +: 4])
           : 8'h00;
        wlim = tx == 8'h01 ? CW'(CLEAR_CYCLES - 1) : CW'(CMD_CYCLES - 1);
        last = state == L1_ADDR || state == L2_ADDR || (state == INIT && idx == 3'd3)
            || (state == L1_CHAR && idx == 3'd1) || (state == L2_CHAR && idx == 3'd7);
    end
    always_comb begin
        state_n = state;
        phase_n = phase;
        cnt_n = cnt + CW'(1);
        idx_n = idx;
        ready_n = ready;
        fd_n = 1'b0;
        shex_n = shex;
        sdat_n = sdat;
        if (state == POWERUP) begin
            if (cnt == CW'(POWERUP_CYCLES - 1)) begin
                state_n = INIT;
                phase_n = SETUP;
                cnt_n = '0;
            end
        end else if (state == SNAP) begin
            state_n = L1_ADDR;
            phase_n = SETUP;
            idx_n = '0;
            cnt_n = '0;
            shex_n = LCDdataHEX;
            sdat_n = LCDdata;
        end else if (phase == SETUP) begin
            phase_n = PULSE;
            cnt_n = '0;
        end else if (phase == PULSE) begin
            if (cnt == CW'(EN_CYCLES - 1)) begin
                phase_n = WAIT;
                cnt_n = '0;
            end
        end else if (cnt == wlim) begin
            phase_n = SETUP;
            cnt_n = '0;
            idx_n = last ? 3'd0 : idx + 3'd1;
            state_n = !last ? state : (state == INIT || state == L2_CHAR) ? SNAP : state_t'(state + 3'd1);
            ready_n = ready | (last && state == INIT);
            fd_n = last && state == L2_CHAR;
        end
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= POWERUP;
            phase <= SETUP;
            cnt <= '0;
            idx <= '0;
            ready <= 1'b0;
            frame_done <= 1'b0;
            shex <= '0;
            sdat <= '0;
        end else begin
            state <= state_n;
            phase <= phase_n;
            cnt <= cnt_n;
            idx <= idx_n;
            ready <= ready_n;
            frame_done <= fd_n;
            shex <= shex_n;
            sdat <= sdat_n;
        end
    end
    assign LCD_DATA = tx;
    assign LCD_RS = state == L1_CHAR || state == L2_CHAR;
    assign LCD_EN = xfer && phase == PULSE;
    assign LCD_RW = 1'b0;
    assign LCD_ON = 1'b1;
    assign LCD_BLON = 1'b1;
endmodule

// File: tb/tb_lcd_hex_driver.sv
// tb_lcd_hex_driver: randomized bench checking the driver against a cycle-timeline model
module tb_lcd_hex_driver;
    localparam int P = 10, E = 2, C = 5, K = 20;
    localparam int LC = 1 + E + C, LK = 1 + E + K;
    localparam int INIT_LEN = 3 * LC + LK, FRAME = 1 + 12 * LC;
    logic clk = 1'b0, reset;
    logic [7:0] LCDdataHEX, LCD_DATA;
    logic [31:0] LCDdata;
    logic LCD_RS, LCD_RW, LCD_EN, LCD_ON, LCD_BLON, ready, frame_done;
    int tests = 0, fails = 0;
    int t = 0, cyc = 0, rdy_t = -1;
    logic [7:0] mhex = 0, prev_d = 0;
    logic [31:0] mdat = 0;
    logic prev_en = 0, prev_rs = 0, prev_rdy = 0;
    bit chk = 0;
    int pt[$], fdt[$];
    logic [7:0] pb[$];
    logic pr[$];
    string hexs = "0123456789ABCDEF";

    lcd_hex_driver #(.POWERUP_CYCLES(P), .EN_CYCLES(E), .CMD_CYCLES(C), .CLEAR_CYCLES(K)) dut (
        .clk(clk), .reset(reset), .LCDdataHEX(LCDdataHEX), .LCDdata(LCDdata),
        .LCD_DATA(LCD_DATA), .LCD_RS(LCD_RS), .LCD_RW(LCD_RW), .LCD_EN(LCD_EN),
        .LCD_ON(LCD_ON), .LCD_BLON(LCD_BLON), .ready(ready), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    function automatic logic [7:0] frame_byte(input int j, input logic [7:0] h, input logic [31:0] d);
        if (j == 0) return 8'h80;
        if (j == 3) return 8'hC0;
        if (j < 3) return hexs[j == 1 ? h[7:4] : h[3:0]];
        return hexs[(d >> (4 * (11 - j))) & 32'hF];
    endfunction

    // {data, rs, rw, en, on, blon, ready, frame_done} expected tt cycles after reset
    function automatic logic [14:0] expect_at(input int tt, input logic [7:0] h, input logic [31:0] d);
        logic [7:0] b;
        logic rs, en, rdy, fd;
        int u, v, w, j, p;
        b = 0; rs = 0; en = 0; rdy = 0; fd = 0;
        if (tt >= P) begin
            u = tt - P;
            if (u < INIT_LEN) begin
                j = u < 3 * LC ? u / LC : 3;
                p = u - j * LC;
                b = j == 0 ? 8'h38 : j == 1 ? 8'h0C : j == 2 ? 8'h06 : 8'h01;
                en = p >= 1 && p <= E;
            end else begin
                v = u - INIT_LEN;
                w = v % FRAME;
                rdy = 1;
                if (w == 0) fd = v >= FRAME;
                else begin
                    j = (w - 1) / LC;
                    p = (w - 1) % LC;
                    b = frame_byte(j, h, d);
                    rs = j == 1 || j == 2 || j >= 4;
                    en = p >= 1 && p <= E;
                end
            end
        end
        return {b, rs, 1'b0, en, 1'b1, 1'b1, rdy, fd};
    endfunction

    initial forever begin
        @(posedge clk);
        cyc++;
        if (reset) t = 0;
        else begin
            if (t >= P + INIT_LEN && (t - P - INIT_LEN) % FRAME == 0) begin
                mhex = LCDdataHEX;
                mdat = LCDdata;
            end
            t++;
        end
    end

    initial forever begin
        @(negedge clk);
        if (chk) begin
            check($sformatf("cycle t=%0d outputs", t),
                  {LCD_DATA, LCD_RS, LCD_RW, LCD_EN, LCD_ON, LCD_BLON, ready, frame_done}, expect_at(t, mhex, mdat));
            if (prev_en && LCD_EN) check("stable while EN", {LCD_DATA, LCD_RS}, {prev_d, prev_rs});
            if (LCD_EN && !prev_en) begin
                pt.push_back(t);
                pb.push_back(LCD_DATA);
                pr.push_back(LCD_RS);
            end
            if (frame_done) fdt.push_back(cyc);
            if (ready && !prev_rdy && rdy_t < 0) rdy_t = t;
        end
        prev_en = LCD_EN;
        prev_rs = LCD_RS;
        prev_d = LCD_DATA;
        prev_rdy = ready;
    end

    task automatic step(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic wait_pulses(input int n, input string what);
        int b = 0;
        while (pb.size() < n && b < 3000) begin
            step(1);
            b++;
        end
        check({"pulses reached ", what}, pb.size() >= n, 1);
    endtask

    task automatic clear_logs();
        pt.delete();
        pb.delete();
        pr.delete();
        fdt.delete();
        rdy_t = -1;
    endtask

    initial begin
        logic [7:0] init_b [4] = '{8'h38, 8'h0C, 8'h06, 8'h01};
        int init_t [4] = '{11, 19, 27, 35};
        logic [7:0] f0 [12] = '{8'h80, 8'h31, 8'h46, 8'hC0, 8'h30, 8'h30, 8'h43, 8'h30, 8'h46, 8'h46, 8'h45, 8'h45};
        logic f0rs [12] = '{0, 1, 1, 0, 1, 1, 1, 1, 1, 1, 1, 1};
        string s1 = "12345678", s2 = "FFFFFFFF";
        int b;
        reset = 1;
        LCDdataHEX = 8'h1F;
        LCDdata = 32'h00C0FFEE;
        step(1);
        chk = 1;
        step(2);
        check("reset outputs", {LCD_DATA, LCD_RS, LCD_RW, LCD_EN, LCD_ON, LCD_BLON, ready, frame_done}, {8'h00, 7'b0001100});
        reset = 0;
        clear_logs();
        wait_pulses(16, "init+frame0");
        for (int i = 0; i < 4; i++) begin
            check($sformatf("init byte %0d", i), pb[i], init_b[i]);
            check($sformatf("init rs %0d", i), pr[i], 0);
            check($sformatf("init pulse time %0d", i), pt[i], init_t[i]);
        end
        check("ready after clear setup", rdy_t - (pt[3] - 1), 23);
        for (int i = 0; i < 12; i++) begin
            check($sformatf("frame0 byte %0d", i), pb[4 + i], f0[i]);
            check($sformatf("frame0 rs %0d", i), pr[4 + i], f0rs[i]);
        end
        LCDdata = 32'h12345678;
        wait_pulses(24, "frame1 4th char");
        LCDdata = 32'hFFFFFFFF;
        wait_pulses(40, "frame2");
        for (int i = 0; i < 8; i++) begin
            check($sformatf("snap frame1 char %0d", i), pb[20 + i], s1[i]);
            check($sformatf("snap frame2 char %0d", i), pb[32 + i], s2[i]);
        end
        for (int i = 0; i < 8; i++) begin
            step($urandom_range(5, 150));
            LCDdataHEX = 8'($urandom);
            LCDdata = $urandom;
        end
        check("frame_done count", fdt.size() >= 3, 1);
        for (int i = 1; i < fdt.size(); i++) check($sformatf("frame_done spacing %0d", i), fdt[i] - fdt[i - 1], 97);
        b = 0;
        while (!(LCD_EN && pb.size() > 4 && (pb.size() - 5) % 12 >= 4) && b < 500) begin
            step(1);
            b++;
        end
        check("reached L2_CHAR pulse", b < 500, 1);
        reset = 1;
        step(1);
        check("EN/ready after mid-pulse reset", {LCD_EN, ready}, 2'b00);
        reset = 0;
        clear_logs();
        wait_pulses(1, "re-init");
        check("re-init first byte", pb[0], 8'h38);
        check("re-init first rs", pr[0], 0);
        check("re-init pulse time", pt[0], 11);
        LCDdataHEX = 8'($urandom);
        LCDdata = $urandom;
        wait_pulses(30, "post-reset frames");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
